// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one 8N1 UART
// transmitter among NREQ byte sources, with a stall/abandon watchdog.
// Ports: Clk/Rst (sync, active-high); per-requester ReqValid/ReqData/
// ReqLast in and one-hot ReqReady out; TxData/TxStart to and TxDone
// from the transmitter; Busy, GrantId and sticky TimeoutErr status.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 17
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NREQ-1:0]         ReqValid,
  input  logic [8*NREQ-1:0]       ReqData,
  input  logic [NREQ-1:0]         ReqLast,
  output logic [NREQ-1:0]         ReqReady,
  output logic [7:0]              TxData,
  output logic                    TxStart,
  input  logic                    TxDone,
  output logic                    Busy,
  output logic [$clog2(NREQ)-1:0] GrantId,
  output logic                    TimeoutErr
);

  localparam int IW = $clog2(NREQ);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [IW:0] N_EXT = (IW+1)'(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            lock_q, lock_d;
  logic [7:0]      data_q, data_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     srch;
  logic [IW-1:0]   cand;
  logic [TO_W-1:0] cnt_inc;
  logic            to_hit;

  // Wrap-around successor; NREQ need not be a power of two.
  function automatic logic [IW-1:0] nxt_ptr(
    input logic [IW-1:0] g
  );
    if (g == IW'(NREQ - 1)) return '0;
    return g + IW'(1);
  endfunction

  // First valid requester at or after the pointer, modulo NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    srch    = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      srch = {1'b0, ptr_q} + (IW+1)'(k);
      if (srch >= N_EXT) srch = srch - N_EXT;
      cand = srch[IW-1:0];
      if (!win_vld && ReqValid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Watchdog counter saturates so it can never wrap back past TIMEOUT.
  assign cnt_inc = (cnt_q == TO_MAX) ? cnt_q
                                     : cnt_q + TO_W'(1);
  assign to_hit  = (cnt_inc == TO_MAX);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    lock_d   = lock_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ReqReady = '0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          ReqReady[win_idx] = 1'b1;
          data_d  = ReqData[{win_idx, 3'b000} +: 8];
          gnt_d   = win_idx;
          lock_d  = ~ReqLast[win_idx];
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (TxDone) begin
          cnt_d = '0;
          if (lock_q) begin
            state_d = HOLD;
          end else begin
            ptr_d   = nxt_ptr(gnt_q);
            state_d = IDLE;
          end
        end else if (to_hit) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          ptr_d   = nxt_ptr(gnt_q);
          state_d = IDLE;
        end
      end
      HOLD: begin
        // Only the locked owner may continue its packet.
        if (ReqValid[gnt_q]) begin
          ReqReady[gnt_q] = 1'b1;
          data_d  = ReqData[{gnt_q, 3'b000} +: 8];
          lock_d  = ~ReqLast[gnt_q];
          state_d = START;
        end else begin
          cnt_d = cnt_inc;
          if (to_hit) begin
            err_d   = 1'b1;
            lock_d  = 1'b0;
            ptr_d   = nxt_ptr(gnt_q);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      lock_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign TxData     = data_q;
  assign TxStart    = (state_q == START);
  assign Busy       = (state_q != IDLE);
  assign GrantId    = gnt_q;
  assign TimeoutErr = err_q;

  a_ready_onehot: assert property (
    @(posedge Clk) disable iff (Rst)
    $onehot0(ReqReady));

  a_no_ready_in_tx: assert property (
    @(posedge Clk) disable iff (Rst)
    (state_q == START || state_q == WAIT) |-> (ReqReady == '0));

  a_cnt_sat: assert property (
    @(posedge Clk) disable iff (Rst)
    cnt_q <= TO_MAX);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus a randomized packet run
// compared against a packet-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 100;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [NREQ-1:0] ReqValid;
  logic [8*NREQ-1:0] ReqData;
  logic [NREQ-1:0] ReqLast;
  logic [NREQ-1:0] ReqReady;
  logic [7:0]      TxData;
  logic            TxStart;
  logic            TxDone;
  logic            Busy;
  logic [1:0]      GrantId;
  logic            TimeoutErr;

  int checks   = 0;
  int failures = 0;

  logic [8:0] rq [NREQ][$];
  logic [8:0] mq [NREQ][$];
  logic [7:0] exp_d [$];
  int         exp_g [$];

  uart_tx_arbiter #(
    .NREQ(NREQ), .TIMEOUT(TMO), .TO_W(8)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqData(ReqData),
    .ReqLast(ReqLast), .ReqReady(ReqReady),
    .TxData(TxData), .TxStart(TxStart),
    .TxDone(TxDone), .Busy(Busy),
    .GrantId(GrantId), .TimeoutErr(TimeoutErr)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; ReqValid = '0; ReqLast = '0;
    ReqData = '0; TxDone = 1'b0;
    step();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; ReqValid = '0; ReqLast = '0;
    ReqData = '0; TxDone = 1'b0;
    step(); step();
    checks++; if (Busy !== 1'b0) begin failures++;
      $display("FAIL rst_busy got=%b exp=0", Busy); end
    checks++; if (TxStart !== 1'b0) begin failures++;
      $display("FAIL rst_start got=%b exp=0", TxStart); end
    checks++; if (ReqReady !== 4'b0) begin failures++;
      $display("FAIL rst_ready got=%b exp=0000", ReqReady); end
    checks++; if (TxData !== 8'h00) begin failures++;
      $display("FAIL rst_data got=%h exp=00", TxData); end
    checks++; if (GrantId !== 2'd0) begin failures++;
      $display("FAIL rst_gnt got=%0d exp=0", GrantId); end
    checks++; if (TimeoutErr !== 1'b0) begin failures++;
      $display("FAIL rst_err got=%b exp=0", TimeoutErr); end
    Rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    ReqData[7:0] = 8'h41; ReqLast = 4'b0001;
    ReqValid = 4'b0001;
    #1;
    checks++; if (ReqReady !== 4'b0001) begin failures++;
      $display("FAIL single_ready got=%b exp=0001", ReqReady); end
    step();
    ReqValid = '0;
    checks++; if (TxStart !== 1'b1 || TxData !== 8'h41) begin
      failures++;
      $display("FAIL single_start got=%b/%h exp=1/41",
               TxStart, TxData); end
    step();
    checks++; if (TxStart !== 1'b0) begin failures++;
      $display("FAIL single_pulse got=%b exp=0", TxStart); end
    repeat (3) step();
    TxDone = 1'b1; step(); TxDone = 1'b0;
    checks++; if (Busy !== 1'b0) begin failures++;
      $display("FAIL single_idle got=%b exp=0", Busy); end
    ReqValid = 4'b0011;
    #1;
    checks++; if (ReqReady !== 4'b0010) begin failures++;
      $display("FAIL single_ptr got=%b exp=0010", ReqReady); end
    ReqValid = '0;
  endtask

  task automatic test_round_robin();
    int extra = 0;
    bit found;
    logic [7:0] ed;
    do_reset();
    ReqData = {8'h40, 8'h30, 8'h20, 8'h10};
    ReqLast = '1; ReqValid = '1;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        step(); found = TxStart;
      end
      checks++;
      if (!found) begin failures++;
        $display("FAIL rr_start k=%0d got=none exp=TxStart", k);
      end else begin
        ed = 8'((k % 4 + 1) * 16);
        if (GrantId !== 2'(k % 4) || TxData !== ed) begin
          failures++;
          $display("FAIL rr_grant k=%0d got=%0d/%h exp=%0d/%h",
                   k, GrantId, TxData, k % 4, ed);
        end
      end
      repeat (3) begin step(); if (TxStart) extra++; end
      TxDone = 1'b1; step(); TxDone = 1'b0;
    end
    ReqValid = '0;
    checks++; if (extra != 0) begin failures++;
      $display("FAIL rr_extra got=%0d exp=0", extra); end
  endtask

  task automatic test_locked();
    logic [7:0] b [3] = '{8'h48, 8'h49, 8'h0A};
    logic [7:0] ex [4] = '{8'h48, 8'h49, 8'h0A, 8'h77};
    logic [7:0] rec [$];
    int grec [$];
    int idx = 0, tx_left = 0, viol = 0, cyc = 0;
    bit r0_on = 0, r0_done = 0, a2, a0;
    do_reset();
    while (rec.size() < 4 && cyc < 300) begin
      ReqValid[2] = (idx < 3);
      ReqData[23:16] = (idx < 3) ? b[idx] : 8'h00;
      ReqLast[2] = (idx == 2);
      ReqValid[0] = r0_on && !r0_done;
      ReqData[7:0] = 8'h77; ReqLast[0] = 1'b1;
      if (tx_left > 0) begin
        tx_left--; TxDone = (tx_left == 0);
      end else TxDone = 1'b0;
      #1;
      a2 = ReqReady[2] & ReqValid[2];
      a0 = ReqReady[0] & ReqValid[0];
      if (ReqReady[0] && rec.size() < 3) viol++;
      if (TxStart) begin
        rec.push_back(TxData); grec.push_back(GrantId);
        tx_left = 3;
      end
      step(); cyc++;
      if (a2) begin idx++; r0_on = 1; end
      if (a0) r0_done = 1;
    end
    ReqValid = '0; ReqLast = '0; TxDone = 1'b0;
    repeat (2) step();
    TxDone = 1'b1; step(); TxDone = 1'b0;
    checks++; if (rec.size() != 4) begin failures++;
      $display("FAIL lock_count got=%0d exp=4", rec.size()); end
    for (int k = 0; k < rec.size() && k < 4; k++) begin
      checks++; if (rec[k] !== ex[k]) begin failures++;
        $display("FAIL lock_data k=%0d got=%h exp=%h",
                 k, rec[k], ex[k]); end
    end
    if (grec.size() == 4) begin
      checks++; if (grec[3] != 0) begin failures++;
        $display("FAIL lock_gnt got=%0d exp=0", grec[3]); end
    end
    checks++; if (viol != 0) begin failures++;
      $display("FAIL lock_viol got=%0d exp=0", viol); end
  endtask

  task automatic test_stall();
    int c = 0;
    do_reset();
    ReqData[15:8] = 8'h55; ReqData[23:16] = 8'h66;
    ReqLast = '1; ReqValid = 4'b0010;
    step();
    ReqValid = 4'b0100;
    step();
    while (!TimeoutErr && c < 150) begin step(); c++; end
    checks++; if (c != TMO) begin failures++;
      $display("FAIL stall_lat got=%0d exp=%0d", c, TMO); end
    checks++; if (Busy !== 1'b0 || ReqReady !== 4'b0100) begin
      failures++;
      $display("FAIL stall_next got=%b/%b exp=0/0100",
               Busy, ReqReady); end
    step();
    checks++;
    if (TxStart !== 1'b1 || TxData !== 8'h66 || GrantId !== 2'd2)
    begin failures++;
      $display("FAIL stall_serve got=%b/%h/%0d exp=1/66/2",
               TxStart, TxData, GrantId); end
    ReqValid = '0;
    step(); TxDone = 1'b1; step(); TxDone = 1'b0;
    checks++; if (TimeoutErr !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_sticky got=%b/%b exp=1/0",
               TimeoutErr, Busy); end
  endtask

  task automatic test_abandon();
    int c = 0;
    do_reset();
    ReqData[15:8] = 8'h31; ReqData[31:24] = 8'h33;
    ReqLast = 4'b1000; ReqValid = 4'b0010;
    step();
    ReqValid = 4'b1000;
    step(); step();
    TxDone = 1'b1; step(); TxDone = 1'b0;
    checks++;
    if (Busy !== 1'b1 || ReqReady !== 4'b0 || TimeoutErr !== 1'b0)
    begin failures++;
      $display("FAIL aband_hold got=%b/%b/%b exp=1/0000/0",
               Busy, ReqReady, TimeoutErr); end
    while (!TimeoutErr && c < 150) begin step(); c++; end
    checks++; if (c != TMO) begin failures++;
      $display("FAIL aband_lat got=%0d exp=%0d", c, TMO); end
    checks++; if (ReqReady !== 4'b1000) begin failures++;
      $display("FAIL aband_next got=%b exp=1000", ReqReady); end
    step();
    checks++;
    if (TxStart !== 1'b1 || TxData !== 8'h33 || GrantId !== 2'd3)
    begin failures++;
      $display("FAIL aband_serve got=%b/%h/%0d exp=1/33/3",
               TxStart, TxData, GrantId); end
    ReqValid = '0;
    step(); TxDone = 1'b1; step(); TxDone = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int bad = 0;
    ReqData[23:16] = 8'h5A; ReqLast = 4'b0100;
    ReqValid = 4'b0100;
    step();
    ReqValid = '0;
    step(); step(); step();
    checks++;
    if (Busy !== 1'b1 || TimeoutErr !== 1'b1 || GrantId !== 2'd2)
    begin failures++;
      $display("FAIL rmw_pre got=%b/%b/%0d exp=1/1/2",
               Busy, TimeoutErr, GrantId); end
    Rst = 1'b1; step(); Rst = 1'b0;
    checks++;
    if (TxData !== 8'h00 || Busy !== 1'b0 || GrantId !== 2'd0 ||
        TimeoutErr !== 1'b0 || TxStart !== 1'b0 ||
        ReqReady !== 4'b0) begin failures++;
      $display("FAIL rmw_rst got=%h/%b/%0d/%b/%b/%b exp=00/0/0/0/0/0",
               TxData, Busy, GrantId, TimeoutErr, TxStart, ReqReady);
    end
    TxDone = 1'b1; step(); TxDone = 1'b0;
    repeat (5) begin
      if (TxStart || Busy) bad++;
      step();
    end
    checks++; if (bad != 0) begin failures++;
      $display("FAIL rmw_stray got=%0d exp=0", bad); end
  endtask

  task automatic test_random();
    int np, nb, ptr, tx_left, cyc, inv, eg;
    bit found, done, gap;
    logic [8:0] w;
    logic [7:0] ed;
    logic [NREQ-1:0] acc, midpkt;
    do_reset();
    exp_d.delete(); exp_g.delete();
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      np = int'($urandom_range(1, 3));
      for (int p = 0; p < np; p++) begin
        nb = int'($urandom_range(1, 4));
        for (int j = 0; j < nb; j++)
          rq[i].push_back({j == nb - 1, 8'($urandom)});
      end
      mq[i] = rq[i];
    end
    ptr = 0;
    do begin
      found = 1'b0;
      for (int k = 0; k < NREQ && !found; k++) begin
        int i;
        i = (ptr + k) % NREQ;
        if (mq[i].size() > 0) begin
          found = 1'b1;
          do begin
            w = mq[i].pop_front();
            exp_d.push_back(w[7:0]); exp_g.push_back(i);
          end while (!w[8]);
          ptr = (i + 1) % NREQ;
        end
      end
    end while (found);
    midpkt = '0; tx_left = 0; cyc = 0; inv = 0; done = 1'b0;
    while (!done && cyc < 20000) begin
      for (int i = 0; i < NREQ; i++) begin
        gap = midpkt[i] && ($urandom_range(0, 3) == 0);
        ReqValid[i] = (rq[i].size() > 0) && !gap;
        ReqData[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
        ReqLast[i] = (rq[i].size() > 0) && rq[i][0][8];
      end
      if (tx_left > 0) begin
        tx_left--; TxDone = (tx_left == 0);
      end else TxDone = 1'b0;
      #1;
      if (!$onehot0(ReqReady) || (ReqReady & ~ReqValid) != 0 ||
          (TxStart && ReqReady != 0)) inv++;
      acc = ReqReady & ReqValid;
      if (TxStart) begin
        checks++;
        if (exp_d.size() == 0) begin failures++;
          $display("FAIL rand_extra got=%h exp=none", TxData);
        end else begin
          ed = exp_d.pop_front(); eg = exp_g.pop_front();
          if (TxData !== ed || GrantId !== 2'(eg)) begin failures++;
            $display("FAIL rand_byte got=%h/%0d exp=%h/%0d",
                     TxData, GrantId, ed, eg); end
        end
        tx_left = int'($urandom_range(1, 30));
      end
      step(); cyc++;
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) begin
          w = rq[i].pop_front(); midpkt[i] = !w[8];
        end
      done = (exp_d.size() == 0) && (tx_left == 0) && !Busy;
    end
    ReqValid = '0; ReqLast = '0; TxDone = 1'b0;
    checks++; if (!done) begin failures++;
      $display("FAIL rand_timeout got=%0d left exp=0", exp_d.size());
    end
    checks++; if (inv != 0) begin failures++;
      $display("FAIL rand_ready got=%0d exp=0", inv); end
    checks++; if (TimeoutErr !== 1'b0) begin failures++;
      $display("FAIL rand_err got=%b exp=0", TimeoutErr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_locked();
    test_stall();
    test_abandon();
    test_reset_mid_wait();
    for (int r = 0; r < 5; r++) test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (8N1 byte serializer with a TxDone pulse) between NREQ byte sources, e.g. gesture-classifier result, status reporter and debug echo.
- Arbitration is round-robin per packet. A requester holds the grant until it presents a byte with ReqLast, so multi-byte messages are never interleaved.
- Sits between the requesters and the transmitter; paces bytes on TxDone.
- A watchdog recovers from a stalled transmitter or an abandoned packet.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 65535, cycles allowed in WAIT or HOLD before abort (covers one 9600-baud byte at 50 MHz).
- TO_W, 17, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- ReqValid  in  NREQ  requester i has a byte ready.
- ReqData  in  8*NREQ  byte of requester i at bits [8i+7:8i].
- ReqLast  in  NREQ  byte of requester i ends its packet.
- ReqReady  out  NREQ  one-hot accept strobe; byte is taken when ReqValid[i] & ReqReady[i].
- TxData  out  8  byte to transmitter; stable from TxStart until TxDone.
- TxStart  out  1  one-cycle pulse that launches the transmitter.
- TxDone  in  1  one-cycle pulse from transmitter at the end of the stop bit.
- Busy  out  1  high in any state except IDLE.
- GrantId  out  clog2(NREQ)  index of the current or last granted requester.
- TimeoutErr  out  1  sticky error flag; cleared only by Rst.

Behaviour:
- Reset (Rst=1 at the edge):
  - State goes to IDLE; round-robin pointer goes to 0.
  - TxData=0, TxStart=0, ReqReady=0, Busy=0, GrantId=0, TimeoutErr=0.
  - Any in-flight byte or packet is dropped. A TxDone arriving afterwards is ignored.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - Search ReqValid starting at pointer index, wrapping modulo NREQ. The first set bit is winner g.
  - ReqReady[g]=1 combinationally in the same cycle; all other bits are 0.
  - On the edge: latch ReqData[g] into TxData, GrantId<=g, latch lock<=~ReqLast[g], go to START.
  - With no valid requester, stay in IDLE.
- START:
  - TxStart=1 for exactly this cycle; clear the counter; go to WAIT.
  - Latency is 1 cycle from the accept edge to TxStart.
  - TxDone seen in START is ignored.
- WAIT:
  - Counter increments each cycle.
  - On TxDone: if lock=1, go to HOLD. If lock=0, set pointer<=(g+1) mod NREQ and go to IDLE.
  - If counter reaches TIMEOUT with no TxDone: set TimeoutErr, clear lock, advance pointer, go to IDLE.
  - TxDone in the same cycle as the timeout: TxDone wins and TimeoutErr is not set.
- HOLD:
  - Only requester g may be served; other requests are ignored.
  - ReqReady[g]=ReqValid[g]. On accept, latch data, update lock from ReqLast[g], go to START.
  - The counter is cleared on HOLD entry and increments while ReqValid[g]=0.
  - At TIMEOUT: set TimeoutErr, clear lock, advance pointer, go to IDLE.
  - The next byte of a packet reaches TxStart no earlier than 2 cycles after TxDone.
- ReqReady is never asserted in START or WAIT and is never multi-hot.
- The pointer advances only at packet end or on abort, which gives fairness per packet.
- No requester waits more than NREQ-1 packets.
- Counter saturates at TIMEOUT and never wraps.

Test Plan:
- Single byte: ReqValid=0001, ReqData[7:0]=8'h41, ReqLast=1.
  - ReqReady=0001 for 1 cycle, then TxStart 1 cycle later with TxData=8'h41.
  - TxDone returns to IDLE with Busy=0 and pointer=1.
- Round-robin: ReqValid=1111 held, all ReqLast=1, bytes 8'h10/8'h20/8'h30/8'h40.
  - Grant order is 0,1,2,3,0; exactly one TxStart per TxDone.
- Locked packet: req 2 sends "HI\n" (ReqLast only on 8'h0A) while req 0 asserts ReqValid.
  - TxData sequence is 8'h48, 8'h49, 8'h0A, then req 0's byte; req 0 gets no ReqReady meanwhile.
- Stalled transmitter: TxDone withheld with TIMEOUT=100 (bench override).
  - TimeoutErr rises 100 cycles after entering WAIT and stays high.
  - Arbiter returns to IDLE and serves the next requester.
- Abandoned packet: req 1 sends a byte with ReqLast=0, then drops ReqValid.
  - HOLD times out, TimeoutErr=1, req 3 is served next.
- Reset mid-WAIT: Rst pulsed during WAIT, then TxDone.
  - All outputs return to reset values the following cycle; the stray TxDone produces no TxStart.
